i2c_cfg_target: RTL and testbench

- I2C target (responder) for the ADV-style register protocol: START, 7-bit address + R/W, sub-address byte, then data bytes with sub-address auto-increment.
- Holds a 256x8 register file, writable from I2C and readable from the host side; pulses a write strobe per data byte.
- Used as the bus-side model of the HDMI transmitter in on-chip self-test loops, and as the config port for FPGA-internal peripherals driven by the existing I2C master.

---
 rtl/i2c_cfg_target_if.sv | 20 ++
 rtl/i2c_cfg_target.sv | 239 +++++++++++++++++++++++
 tb/tb_i2c_cfg_target.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_cfg_target_if.sv
// Host-side port of i2c_cfg_target: registered register read plus a per-byte write strobe.
// Read data lags reg_addr by one cycle; no backpressure, strobes are single-cycle pulses.
interface i2c_cfg_target_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_rdata;
  logic       wr_stb;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  modport master (
    output reg_addr,
    input  reg_rdata, wr_stb, wr_addr, wr_data, busy
  );

  modport slave (
    input  reg_addr,
    output reg_rdata, wr_stb, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/i2c_cfg_target.sv
// I2C register target (START, addr+R/W, sub-address, auto-increment data) over a 256x8 file.
// Never stretches SCL; host read latency 1 cycle. Read transfers only with I2C_CFG_TARGET_READ_EN.
module i2c_cfg_target #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h39,
  parameter int unsigned FILTER     = 3
) (
  input  logic            iCLK,
  input  logic            iRST_N,
  input  logic            I2C_SCL,
  inout  wire             I2C_SDA,
  i2c_cfg_target_if.slave host
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_SUB, S_SUB_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_t;

  localparam logic [3:0] FCNT = 4'(FILTER - 1);

  state_t     state, state_nxt;
  logic [1:0] scl_sync, sda_sync;
  logic [3:0] scl_cnt, sda_cnt;
  logic       scl_f, sda_f, scl_d, sda_d;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [2:0] bit_cnt;
  logic       byte_done;
  logic [6:0] shreg;
  logic [7:0] rx_byte;
  logic       bit_state, byte_rx;
  logic       addr_hit, addr_rw;
  logic [7:0] ptr;
  logic [7:0] regs [256];
  logic       sda_oe, sda_oe_nxt;
  logic       busy_nxt;
`ifdef I2C_CFG_TARGET_READ_EN
  logic [6:0] tx_sh;
  logic       ack_bit;
`endif

  // Bus lines idle high, so the synchronisers and filters reset to 1.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_cnt  <= '0;
      sda_cnt  <= '0;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], I2C_SCL};
      sda_sync <= {sda_sync[0], I2C_SDA};
      if (scl_sync[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == FCNT) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 4'd1;
      end
      if (sda_sync[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == FCNT) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 4'd1;
      end
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;
  assign rx_byte   = {shreg, sda_f};

`ifdef I2C_CFG_TARGET_READ_EN
  assign bit_state = (state == S_ADDR) || (state == S_SUB) || (state == S_WDATA) ||
                     (state == S_RDATA);
`else
  assign bit_state = (state == S_ADDR) || (state == S_SUB) || (state == S_WDATA);
`endif
  assign byte_rx = scl_rise & bit_state & (bit_cnt == 3'd7);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Byte boundaries are acted on at the SCL fall after bit 8 so SDA only moves while SCL is low.
  always_comb begin
    state_nxt = state;
    if (stop_det) begin
      state_nxt = S_IDLE;
    end else if (start_det) begin
      state_nxt = S_ADDR;
    end else if (scl_fall) begin
      case (state)
        S_ADDR: begin
          if (byte_done) begin
            if (!addr_hit)     state_nxt = S_IGNORE;
            else if (!addr_rw) state_nxt = S_ADDR_ACK;
            else begin
`ifdef I2C_CFG_TARGET_READ_EN
              state_nxt = S_ADDR_ACK;
`else
              state_nxt = S_IGNORE;
`endif
            end
          end
        end
        S_ADDR_ACK: begin
`ifdef I2C_CFG_TARGET_READ_EN
          state_nxt = addr_rw ? S_RDATA : S_SUB;
`else
          state_nxt = S_SUB;
`endif
        end
        S_SUB:       if (byte_done) state_nxt = S_SUB_ACK;
        S_SUB_ACK:   state_nxt = S_WDATA;
        S_WDATA:     if (byte_done) state_nxt = S_WDATA_ACK;
        S_WDATA_ACK: state_nxt = S_WDATA;
`ifdef I2C_CFG_TARGET_READ_EN
        S_RDATA:     if (byte_done) state_nxt = S_RDATA_ACK;
        S_RDATA_ACK: state_nxt = ack_bit ? S_IGNORE : S_RDATA;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    sda_oe_nxt = sda_oe;
    busy_nxt   = (state_nxt == S_ADDR_ACK) || (state_nxt == S_SUB) ||
                 (state_nxt == S_SUB_ACK)  || (state_nxt == S_WDATA) ||
                 (state_nxt == S_WDATA_ACK) || (state_nxt == S_RDATA) ||
                 (state_nxt == S_RDATA_ACK);
    if (state_nxt != state) begin
      sda_oe_nxt = 1'b0;
      case (state_nxt)
        S_ADDR_ACK, S_SUB_ACK, S_WDATA_ACK: sda_oe_nxt = 1'b1;
`ifdef I2C_CFG_TARGET_READ_EN
        S_RDATA: sda_oe_nxt = ~regs[ptr][7];
`endif
        default: ;
      endcase
    end
`ifdef I2C_CFG_TARGET_READ_EN
    else if (state == S_RDATA && scl_fall) begin
      sda_oe_nxt = ~tx_sh[6];
    end
`endif
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      bit_cnt      <= '0;
      byte_done    <= 1'b0;
      shreg        <= '0;
      addr_hit     <= 1'b0;
      addr_rw      <= 1'b0;
      ptr          <= '0;
      sda_oe       <= 1'b0;
      host.busy    <= 1'b0;
      host.wr_stb  <= 1'b0;
      host.wr_addr <= '0;
      host.wr_data <= '0;
    end else begin
      host.wr_stb <= 1'b0;
      sda_oe      <= sda_oe_nxt;
      host.busy   <= busy_nxt;
      if (start_det || stop_det) begin
        bit_cnt   <= '0;
        byte_done <= 1'b0;
      end else begin
        if (scl_fall) byte_done <= 1'b0;
        if (scl_rise && bit_state) begin
          shreg   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (byte_rx) begin
          byte_done <= 1'b1;
          case (state)
            S_ADDR: begin
              addr_hit <= (rx_byte[7:1] == SLAVE_ADDR);
              addr_rw  <= rx_byte[0];
            end
            S_SUB: ptr <= rx_byte;
            S_WDATA: begin
              host.wr_stb  <= 1'b1;
              host.wr_addr <= ptr;
              host.wr_data <= rx_byte;
              ptr          <= ptr + 8'd1;
            end
`ifdef I2C_CFG_TARGET_READ_EN
            S_RDATA: ptr <= ptr + 8'd1;
`endif
            default: ;
          endcase
        end
      end
    end
  end

`ifdef I2C_CFG_TARGET_READ_EN
  // tx_sh holds the not-yet-driven bits; bit 7 goes onto the bus as the state is entered.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      tx_sh   <= '0;
      ack_bit <= 1'b1;
    end else begin
      if (state_nxt == S_RDATA && state != S_RDATA) tx_sh <= regs[ptr][6:0];
      else if (state == S_RDATA && scl_fall)        tx_sh <= {tx_sh[5:0], 1'b0};
      if (state == S_RDATA_ACK && scl_rise) ack_bit <= sda_f;
    end
  end
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < 256; i++) regs[i] <= '0;
    end else if (byte_rx && state == S_WDATA) begin
      regs[ptr] <= rx_byte;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) host.reg_rdata <= '0;
    else         host.reg_rdata <= regs[host.reg_addr];
  end

  assign I2C_SDA = sda_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_cfg_target.sv
// Bench for i2c_cfg_target: bit-banged I2C controller, register-file reference model, strobe scoreboard.
module tb_i2c_cfg_target;
  logic iCLK = 1'b0;
  logic iRST_N = 1'b0;
  logic scl = 1'b1;
  logic sda_low = 1'b0;
  wire  sda;

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_cfg_target_if hif ();

  i2c_cfg_target #(.SLAVE_ADDR(7'h39), .FILTER(3)) dut (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .I2C_SCL (scl),
    .I2C_SDA (sda),
    .host    (hif)
  );

  always #5 iCLK = ~iCLK;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] mregs [256];
  int         mptr = 0;
  logic [7:0] wbuf [4];
  logic [15:0] stb_q [$];
  logic [15:0] exp_q [$];
  bit         busy_seen = 0;
  bit         dut_drove = 0;

  always @(negedge iCLK) begin
    if (hif.wr_stb) stb_q.push_back({hif.wr_addr, hif.wr_data});
    if (hif.busy) busy_seen = 1;
    if (!sda_low && sda === 1'b0) dut_drove = 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    tick(5);  sda_low = !b;
    tick(10); scl = 1'b1;
    tick(5);  s = sda;
    tick(5);  scl = 1'b0;
  endtask

  task automatic i2c_start();
    if (scl == 1'b0) begin
      tick(5);  sda_low = 1'b0;
      tick(10); scl = 1'b1;
    end
    tick(10); sda_low = 1'b1;
    tick(10); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(5);  sda_low = 1'b1;
    tick(10); scl = 1'b1;
    tick(10); sda_low = 1'b0;
    tick(10);
  endtask

  // acked = 1 when the target pulled SDA low in the ninth clock.
  task automatic wr_byte(input logic [7:0] d, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, s);
    acked = !s;
  endtask

  task automatic rd_byte(output logic [7:0] d, input logic nack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(nack, s);
  endtask

  task automatic host_chk(input logic [7:0] a, input string tag);
    hif.reg_addr = a;
    tick(1);
    check(tag, {24'd0, hif.reg_rdata}, {24'd0, mregs[a]});
  endtask

  task automatic begin_xfer();
    stb_q.delete();
    exp_q.delete();
    busy_seen = 0;
    dut_drove = 0;
  endtask

  task automatic end_checks(input string tag, input bit hit);
    check({tag, "_stb_count"}, exp_q.size(), stb_q.size());
    for (int i = 0; i < exp_q.size() && i < stb_q.size(); i++)
      check({tag, "_stb_addr_data"}, {16'd0, stb_q[i]}, {16'd0, exp_q[i]});
    check({tag, "_busy_seen"}, {31'd0, busy_seen}, {31'd0, hit});
    check({tag, "_sda_driven"}, {31'd0, dut_drove}, {31'd0, hit});
    check({tag, "_busy_after_stop"}, {31'd0, hif.busy}, 32'd0);
  endtask

  // Write transfer of n bytes from wbuf; the model only changes if the address matches.
  task automatic do_write(input logic [6:0] a7, input logic [7:0] sub, input int n,
                          input string tag);
    logic acked;
    bit   hit;
    hit = (a7 == 7'h39);
    begin_xfer();
    i2c_start();
    wr_byte({a7, 1'b0}, acked);
    check({tag, "_addr_ack"}, {31'd0, acked}, {31'd0, hit});
    wr_byte(sub, acked);
    check({tag, "_sub_ack"}, {31'd0, acked}, {31'd0, hit});
    if (hit) mptr = sub;
    for (int i = 0; i < n; i++) begin
      wr_byte(wbuf[i], acked);
      check({tag, "_data_ack"}, {31'd0, acked}, {31'd0, hit});
      if (hit) begin
        exp_q.push_back({mptr[7:0], wbuf[i]});
        mregs[mptr] = wbuf[i];
        mptr = (mptr + 1) % 256;
      end
    end
    i2c_stop();
    tick(4);
    end_checks(tag, hit);
  endtask

  initial begin
    logic       acked;
    logic       s;
    logic [7:0] rd0, rd1;
    logic [6:0] a7;
    int         n;

    hif.reg_addr = 8'h00;
    for (int i = 0; i < 256; i++) mregs[i] = 8'h00;
    tick(5);
    iRST_N = 1'b1;
    tick(5);
    check("rst_wr_stb", {31'd0, hif.wr_stb}, 32'd0);
    check("rst_wr_addr", {24'd0, hif.wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, hif.wr_data}, 32'd0);
    check("rst_busy", {31'd0, hif.busy}, 32'd0);
    check("rst_rdata", {24'd0, hif.reg_rdata}, 32'd0);
    check("rst_sda", {31'd0, sda}, 32'd1);

    // Single write, then host readback
    wbuf[0] = 8'h03;
    do_write(7'h39, 8'h98, 1, "t1");
    host_chk(8'h98, "t1_rdata");

    // Foreign address: no ACK, no write
    wbuf[0] = 8'h55;
    do_write(7'h3A, 8'h98, 1, "t2");
    host_chk(8'h98, "t2_rdata_unchanged");

    // Burst across 0xFF wrap
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    do_write(7'h39, 8'hFE, 3, "t3");
    host_chk(8'hFE, "t3_rd_fe");
    host_chk(8'hFF, "t3_rd_ff");
    host_chk(8'h00, "t3_rd_00");

    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A; wbuf[2] = 8'hC3;
    do_write(7'h39, 8'h10, 3, "t4_setup");
`ifdef I2C_CFG_TARGET_READ_EN
    begin_xfer();
    i2c_start();
    wr_byte(8'h72, acked);
    check("t4_wr_addr_ack", {31'd0, acked}, 32'd1);
    wr_byte(8'h10, acked);
    check("t4_sub_ack", {31'd0, acked}, 32'd1);
    i2c_start();
    wr_byte(8'h73, acked);
    check("t4_rd_addr_ack", {31'd0, acked}, 32'd1);
    rd_byte(rd0, 1'b0);
    rd_byte(rd1, 1'b1);
    i2c_stop();
    check("t4_rd_byte0", {24'd0, rd0}, {24'd0, mregs[8'h10]});
    check("t4_rd_byte1", {24'd0, rd1}, {24'd0, mregs[8'h11]});
    check("t4_stb_count", stb_q.size(), 32'd0);
    begin_xfer();
    i2c_start();
    wr_byte(8'h73, acked);
    check("t4_cur_addr_ack", {31'd0, acked}, 32'd1);
    rd_byte(rd0, 1'b1);
    i2c_stop();
    tick(4);
    check("t4_ptr_end", {24'd0, rd0}, {24'd0, mregs[8'h12]});
    check("t4_busy_after_stop", {31'd0, hif.busy}, 32'd0);
`else
    begin_xfer();
    i2c_start();
    wr_byte(8'h73, acked);
    check("t4_rd_addr_nack", {31'd0, acked}, 32'd0);
    rd_byte(rd0, 1'b1);
    i2c_stop();
    tick(4);
    check("t4_busy_seen", {31'd0, busy_seen}, 32'd0);
    check("t4_sda_driven", {31'd0, dut_drove}, 32'd0);
`endif

    // STOP after 5 data bits: partial byte dropped
    begin_xfer();
    i2c_start();
    wr_byte(8'h72, acked);
    wr_byte(8'h20, acked);
    for (int i = 0; i < 5; i++) bit_xfer(1'b1, s);
    i2c_stop();
    tick(4);
    check("t5_stb_count", stb_q.size(), 32'd0);
    check("t5_busy_after_stop", {31'd0, hif.busy}, 32'd0);
    host_chk(8'h20, "t5_rdata_unchanged");
    wbuf[0] = 8'h6B;
    do_write(7'h39, 8'h20, 1, "t5_next");
    host_chk(8'h20, "t5_next_rdata");

    // Reset during the address ACK low phase
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_xfer(rd0[0] | 1'b1 ? (8'h72 >> i) & 1 : 1'b0, s);
    tick(5); sda_low = 1'b0;
    tick(5);
    check("t6_ack_driven", {31'd0, sda}, 32'd0);
    iRST_N = 1'b0;
    #1;
    check("t6_sda_released", {31'd0, sda}, 32'd1);
    check("t6_busy_reset", {31'd0, hif.busy}, 32'd0);
    check("t6_rdata_reset", {24'd0, hif.reg_rdata}, 32'd0);
    tick(3);
    iRST_N = 1'b1;
    for (int i = 0; i < 256; i++) mregs[i] = 8'h00;
    tick(5);
    i2c_stop();
    host_chk(8'h98, "t6_reg98_cleared");
    host_chk(8'h10, "t6_reg10_cleared");
    wbuf[0] = 8'h5C;
    do_write(7'h39, 8'h42, 1, "t6_next");
    host_chk(8'h42, "t6_next_rdata");

    // Randomised write transfers against the model
    for (int t = 0; t < 12; t++) begin
      a7 = 7'h39;
      if ($urandom_range(0, 3) == 0) begin
        a7 = 7'($urandom_range(0, 127));
        if (a7 == 7'h39) a7 = 7'h3A;
      end
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom_range(0, 255));
      do_write(a7, 8'($urandom_range(0, 255)), n, "rnd");
    end

    for (int a = 0; a < 256; a++) host_chk(8'(a), "sweep");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
